sample_stream_receiver: RTL

Receiving end of the 12-bit serial sample link (SCL/SS/MOSI, ~100 kHz SCL) that the data collector drives. It oversamples the three link lines with the 50 MHz system clock and deserializes MSB-first 12-bit frames. Complete frames are buffered in a small FIFO and presented on a valid/ready stream, giving an FPGA-side endpoint for loopback checking and for board-to-board sample transfer.

---
 rtl/link_pkg.sv | 14 +
 rtl/sample_fifo.sv | 61 ++++++
 rtl/sample_stream_receiver.sv | 123 ++++++++++++
 3 files changed

// File: rtl/link_pkg.sv
// Shared constants and types for the 12-bit serial sample link.
// The data collector on the far end uses the same width/depth constants.
package link_pkg;

   localparam int SAMPLE_WIDTH = 12;
   localparam int SAMPLE_DEPTH = 8;

   typedef enum logic [1:0] {
      WAIT_IDLE,
      IDLE,
      SHIFT
   } rx_state_t;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO for received samples.
// Ports:
//   clk, rst       clock, synchronous active-low reset
//   push, din      write request and data (ignored when full unless popping)
//   pop            read request (ignored when empty)
//   dout           head sample, combinational from the read pointer
//   fill_level     samples stored, 0..DEPTH
//   full, empty    status flags
module sample_fifo #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic [$clog2(DEPTH):0]     fill_level,
   output logic                       full,
   output logic                       empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (fill_level == '0);
   assign full    = (fill_level == FULL_LVL);
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot, so push at full is legal then.
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fill_level <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   fill_level <= fill_level + 1'b1;
            2'b01:   fill_level <= fill_level - 1'b1;
            default: fill_level <= fill_level;
         endcase
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/sample_stream_receiver.sv
// Receiver for the SCL/SS/MOSI 12-bit sample link. Oversamples the link
// with clk, deserializes MSB-first frames, buffers complete frames in a
// FIFO and presents them on a valid/ready stream.
// Ports:
//   clk, rst            system clock, synchronous active-low reset
//   SCL, SS, MOSI       asynchronous link inputs (SS active-low)
//   out_data/out_valid/out_ready   sample stream (pop on valid&&ready)
//   fill_level          samples buffered
//   frame_err           1-cycle pulse: frame closed with bit count != WIDTH
//   overflow            1-cycle pulse: good frame dropped, FIFO full
module sample_stream_receiver
   import link_pkg::*;
#(
   parameter int WIDTH = SAMPLE_WIDTH,
   parameter int DEPTH = SAMPLE_DEPTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    SCL,
   input  logic                    SS,
   input  logic                    MOSI,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [$clog2(DEPTH):0]  fill_level,
   output logic                    frame_err,
   output logic                    overflow
);

   localparam int CW = $clog2(WIDTH + 2);
   localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_SAT  = CW'(WIDTH + 1);

   logic scl_s1, scl_s2, scl_d;
   logic ss_s1,  ss_s2,  ss_d;
   logic mosi_s1, mosi_s2;      // data is only sampled, no edge needed
   logic [1:0] primed_q;

   rx_state_t        state;
   logic [WIDTH-1:0] shift_reg;
   logic [CW-1:0]    bit_cnt;

   logic scl_rise, ss_rise, ss_fall;
   logic pop, close, good_len, push, full, empty;

   always_ff @(posedge clk) begin
      if (!rst) begin
         {scl_s1, scl_s2, scl_d} <= 3'b000;
         {ss_s1,  ss_s2,  ss_d}  <= 3'b111;
         {mosi_s1, mosi_s2}      <= 2'b00;
         primed_q                <= 2'b00;
      end else begin
         {scl_s1, scl_s2, scl_d} <= {SCL, scl_s1, scl_s2};
         {ss_s1,  ss_s2,  ss_d}  <= {SS,  ss_s1,  ss_s2};
         {mosi_s1, mosi_s2}      <= {MOSI, mosi_s1};
         primed_q                <= {primed_q[0], 1'b1};
      end
   end

   assign scl_rise = scl_s2 & ~scl_d;
   assign ss_rise  = ss_s2  & ~ss_d;
   assign ss_fall  = ~ss_s2 & ss_d;

   assign pop      = out_valid && out_ready;
   assign close    = (state == SHIFT) && ss_rise;
   assign good_len = (bit_cnt == CNT_FULL);
   assign push     = close && good_len && (!full || pop);
   assign out_valid = !empty;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= WAIT_IDLE;
         shift_reg <= '0;
         bit_cnt   <= '0;
         frame_err <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         overflow  <= 1'b0;
         case (state)
            // ss_s2 still carries its reset value for the first cycles after
            // release; primed_q[1] ensures we only trust a real SS sample,
            // so a frame already in progress is never joined mid-way.
            WAIT_IDLE: if (primed_q[1] && ss_s2) state <= IDLE;
            IDLE: begin
               if (ss_fall) begin
                  shift_reg <= '0;
                  bit_cnt   <= '0;
                  state     <= SHIFT;
               end
            end
            SHIFT: begin
               // SS close takes priority over a coincident SCL edge.
               if (ss_rise) begin
                  state <= IDLE;
                  if (!good_len)          frame_err <= 1'b1;
                  else if (full && !pop)  overflow  <= 1'b1;
               end else if (scl_rise) begin
                  shift_reg <= {shift_reg[WIDTH-2:0], mosi_s2};
                  if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 1'b1;
               end
            end
            default: state <= WAIT_IDLE;
         endcase
      end
   end

   sample_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .pop        (pop),
      .din        (shift_reg),
      .dout       (out_data),
      .fill_level (fill_level),
      .full       (full),
      .empty      (empty)
   );

endmodule
